wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single scoreboard writeback port between NR_REQ functional-unit result producers: LOAD, STORE, ALU, CTRL_FLOW, MULT and CSR.
- Each producer presents trans_id, result and exception with a valid/ready handshake.
- The arbiter picks one producer per cycle, round-robin, and registers the winner into a one-entry output stage feeding the scoreboard.
- Sits between the EX-stage units and the scoreboard write logic. Flush drops in-flight writeback on mispredict or exception.

Parameters:
- NR_REQ, 6, number of requesting functional units (index = fu_t value minus 1).
- DATA_W, 64, result width.
- TRANS_ID_W, TRANS_ID_BITS (3), scoreboard transaction-id width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  drop output entry, suppress grants this cycle.
- req_valid_i  in  NR_REQ  per-unit result valid.
- req_ready_o  out  NR_REQ  per-unit grant (one-hot or zero).
- req_trans_id_i  in  NR_REQ x TRANS_ID_W  per-unit trans_id.
- req_result_i  in  NR_REQ x DATA_W  per-unit result.
- req_ex_i  in  NR_REQ x exception  per-unit exception struct (cause, tval, valid).
- wb_valid_o  out  1  writeback entry valid.
- wb_ready_i  in  1  scoreboard accepts entry.
- wb_trans_id_o  out  TRANS_ID_W  winning trans_id.
- wb_result_o  out  DATA_W  winning result.
- wb_ex_o  out  exception  winning exception.
- wb_src_o  out  $clog2(NR_REQ)  index of winning unit (debug / perf).

Behaviour:
- Reset (rst_i=1 at edge):
  - wb_valid_o=0.
  - wb_trans_id_o, wb_result_o, wb_ex_o, wb_src_o all 0.
  - rr_ptr=0.
  - req_ready_o=0 combinationally while rst_i=1.
  - Reset overrides flush and any handshake in the same cycle.
- Slot free: slot_free = !wb_valid_o | wb_ready_i.
- Arbitration:
  - Combinational, only when slot_free & !flush_i & !rst_i.
  - Scan req_valid_i starting at rr_ptr, ascending, wrapping at NR_REQ-1 -> 0.
  - The first valid requester i wins; req_ready_o[i]=1, all others 0.
  - No valid requester -> req_ready_o=0.
  - req_ready_o depends on req_valid_i, rr_ptr, wb_valid_o, wb_ready_i, flush_i and rst_i only, never on data.
- Transfer on grant i at the clock edge:
  - Output register loads req_*[i] and wb_src_o=i; wb_valid_o=1.
  - rr_ptr = (i+1) mod NR_REQ.
- Slot freed, no grant: wb_valid_o=0; rr_ptr unchanged.
- Backpressure:
  - While wb_valid_o & !wb_ready_i, all outputs are held bit-stable and req_ready_o=0.
- Latency:
  - A result granted in cycle N appears on wb_*_o in cycle N+1.
  - Throughput is 1 per cycle when wb_ready_i is held high.
- Flush:
  - flush_i=1 -> next cycle wb_valid_o=0, even if wb_ready_i=0 (entry discarded).
  - No grant that cycle; rr_ptr unchanged.
  - Requesters are responsible for their own flush; the arbiter never acks during flush.
- Simultaneous scoreboard accept and new grant: back-to-back reload in the same edge, no bubble.
- Fairness: any continuously valid requester is granted within NR_REQ grants.
- Exceptions: carried as data; the arbiter does not prioritise exception entries over plain results.
- Assertions:
  - req_ready_o is onehot0.
  - Output is stable under backpressure.
  - No grant during flush or reset.
  - trans_id is never modified.

Decomposition:
- Shared package: add wb_entry_t (trans_id, result, exception) and NR_WB_REQ=6.
  - Reuses exception and TRANS_ID_BITS.
- Sub-module rr_arbiter (pure combinational): inputs req vector and pointer; outputs one-hot grant and encoded index.
  - Reusable for LSU and issue arbitration.
- Top holds the output register and rr_ptr.

Test Plan:
- Reset release, all req_valid_i=0 -> wb_valid_o=0 and req_ready_o=0 for 10 cycles.
- req_valid_i=6'b000101 held, wb_ready_i=1, trans_ids 2 and 5 -> wb_trans_id_o sequence 2,5,2,5 on consecutive cycles with wb_src_o 0,2,0,2.
- All 6 valid, wb_ready_i=1, rr_ptr=0 -> grants 0,1,2,3,4,5,0 over cycles; each unit gets exactly 1 grant per 6 cycles.
- Grant unit 3 (result 64'hDEAD_BEEF), wb_ready_i=0 for 4 cycles -> wb_result_o=64'hDEAD_BEEF held and req_ready_o=0 for those 4 cycles; accepted in cycle 5, next grant in the same cycle.
- wb_valid_o=1, wb_ready_i=0, flush_i=1 with unit 1 valid -> next cycle wb_valid_o=0, req_ready_o[1]=0 during flush, rr_ptr unchanged.
- Unit 4 valid with ex.valid=1, cause=LD_ACCESS_FAULT, tval=64'h80 -> wb_ex_o matches bit-exactly one cycle later.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the scoreboard writeback arbiter.
// Exceptions travel through the arbiter as opaque data alongside the result.
package wb_arbiter_pkg;

   localparam int TRANS_ID_BITS = 3;
   localparam int NR_WB_REQ     = 6;
   localparam int WB_DATA_W     = 64;

   localparam logic [63:0] LD_ACCESS_FAULT = 64'd5;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [WB_DATA_W-1:0]     result;
      exception_t               ex;
   } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant and its encoded index; reusable wherever N agents share a port.
module wb_arbiter_rr_arbiter #(
   parameter  int N     = 6,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   int               pos;
   logic [IDX_W-1:0] pos_idx;
   logic             found;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      found   = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         pos_idx = IDX_W'(pos);
         if (!found && req[pos_idx]) begin
            found        = 1'b1;
            gnt[pos_idx] = 1'b1;
            idx          = pos_idx;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: picks one functional-unit result per cycle
// and registers it into a single-entry stage feeding the scoreboard.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter  int NR_REQ     = NR_WB_REQ,
   parameter  int DATA_W     = WB_DATA_W,
   parameter  int TRANS_ID_W = TRANS_ID_BITS,
   localparam int SRC_W      = $clog2(NR_REQ)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   input  logic [NR_REQ-1:0]                   req_valid_i,
   output logic [NR_REQ-1:0]                   req_ready_o,
   input  logic [NR_REQ-1:0][TRANS_ID_W-1:0]   req_trans_id_i,
   input  logic [NR_REQ-1:0][DATA_W-1:0]       req_result_i,
   input  exception_t [NR_REQ-1:0]             req_ex_i,
   output logic                                wb_valid_o,
   input  logic                                wb_ready_i,
   output logic [TRANS_ID_W-1:0]               wb_trans_id_o,
   output logic [DATA_W-1:0]                   wb_result_o,
   output exception_t                          wb_ex_o,
   output logic [SRC_W-1:0]                    wb_src_o
);

   // Handshake: a unit's result transfers on a rising edge where req_valid_i[i]
   // and req_ready_o[i] are both high; the output entry leaves on an edge where
   // wb_valid_o and wb_ready_i are both high. Ready never looks at payload data.

   logic [SRC_W-1:0]  rr_ptr;
   logic [NR_REQ-1:0] rr_gnt;
   logic [SRC_W-1:0]  gnt_idx;
   logic              slot_free;
   logic              arb_en;
   logic              grant;

   wb_arbiter_rr_arbiter #(.N(NR_REQ)) u_rr (
      .req (req_valid_i),
      .ptr (rr_ptr),
      .gnt (rr_gnt),
      .idx (gnt_idx)
   );

   assign slot_free   = !wb_valid_o || wb_ready_i;
   assign arb_en      = slot_free && !flush_i && !rst_i;
   assign req_ready_o = arb_en ? rr_gnt : '0;
   assign grant       = |req_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_valid_o    <= 1'b0;
         wb_trans_id_o <= '0;
         wb_result_o   <= '0;
         wb_ex_o       <= '0;
         wb_src_o      <= '0;
         rr_ptr        <= '0;
      end else if (flush_i) begin
         // Entry is discarded even under backpressure; payload is left as-is.
         wb_valid_o <= 1'b0;
      end else if (grant) begin
         wb_valid_o    <= 1'b1;
         wb_trans_id_o <= req_trans_id_i[gnt_idx];
         wb_result_o   <= req_result_i[gnt_idx];
         wb_ex_o       <= req_ex_i[gnt_idx];
         wb_src_o      <= gnt_idx;
         rr_ptr        <= (gnt_idx == SRC_W'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (wb_ready_i) begin
         wb_valid_o <= 1'b0;
      end
   end

   logic [TRANS_ID_W-1:0] sel_trans_id;
   assign sel_trans_id = req_trans_id_i[gnt_idx];

   a_ready_onehot0 : assert property (@(posedge clk_i) $onehot0(req_ready_o));

   a_no_grant_flush_rst : assert property (@(posedge clk_i)
      (flush_i || rst_i) |-> (req_ready_o == '0));

   a_stable_backpressure : assert property (@(posedge clk_i) disable iff (rst_i)
      (wb_valid_o && !wb_ready_i && !flush_i) |=>
      $stable({wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_o, wb_src_o}));

   a_trans_id_kept : assert property (@(posedge clk_i) disable iff (rst_i)
      grant |=> (wb_trans_id_o == $past(sel_trans_id)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter with hand-written reset sequences.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  flush;
   logic [5:0]            req_valid;
   logic [5:0]            req_ready;
   logic [5:0][2:0]       req_trans_id;
   logic [5:0][63:0]      req_result;
   exception_t [5:0]      req_ex;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [2:0]            wb_trans_id;
   logic [63:0]           wb_result;
   exception_t            wb_ex;
   logic [2:0]            wb_src;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       flush;
      logic [5:0] vld;
      logic       wrdy;
      logic [5:0] exp_rdy;
      logic       exp_wv;
      logic [2:0] exp_src;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_trans_id_i (req_trans_id),
      .req_result_i   (req_result),
      .req_ex_i       (req_ex),
      .wb_valid_o     (wb_valid),
      .wb_ready_i     (wb_ready),
      .wb_trans_id_o  (wb_trans_id),
      .wb_result_o    (wb_result),
      .wb_ex_o        (wb_ex),
      .wb_src_o       (wb_src)
   );

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic fl, input logic [5:0] v, input logic w,
                               input logic [5:0] er, input logic ewv, input logic [2:0] es);
      vec_t t;
      t.flush = fl; t.vld = v; t.wrdy = w;
      t.exp_rdy = er; t.exp_wv = ewv; t.exp_src = es;
      vecs.push_back(t);
   endfunction

   initial begin
      rst       = 1'b1;
      flush     = 1'b1;
      req_valid = 6'b111111;
      wb_ready  = 1'b1;
      // Unit 0 carries trans_id 2 and unit 2 carries trans_id 5.
      req_trans_id = {3'd3, 3'd6, 3'd1, 3'd5, 3'd4, 3'd2};
      for (int i = 0; i < 6; i++) begin
         req_result[i] = 64'h1111_0000_0000_0000 + 64'(i);
         req_ex[i]     = '0;
      end
      req_result[3] = 64'hDEAD_BEEF;
      req_ex[1] = exception_t'{cause: 64'd2, tval: 64'h1234, valid: 1'b1};
      req_ex[4] = exception_t'{cause: LD_ACCESS_FAULT, tval: 64'h80, valid: 1'b1};

      for (int i = 0; i < 10; i++) add(1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0, 3'd0);
      add(1'b0, 6'b000101, 1'b1, 6'b000001, 1'b1, 3'd0);
      add(1'b0, 6'b000101, 1'b1, 6'b000100, 1'b1, 3'd2);
      add(1'b0, 6'b000101, 1'b1, 6'b000001, 1'b1, 3'd0);
      add(1'b0, 6'b000101, 1'b1, 6'b000100, 1'b1, 3'd2);
      add(1'b0, 6'b100000, 1'b1, 6'b100000, 1'b1, 3'd5);
      for (int i = 0; i < 7; i++)
         add(1'b0, 6'b111111, 1'b1, 6'(1 << (i % 6)), 1'b1, 3'(i % 6));
      add(1'b0, 6'b001000, 1'b1, 6'b001000, 1'b1, 3'd3);
      for (int i = 0; i < 4; i++) add(1'b0, 6'b010000, 1'b0, 6'b000000, 1'b1, 3'd3);
      add(1'b0, 6'b010000, 1'b1, 6'b010000, 1'b1, 3'd4);
      add(1'b1, 6'b000010, 1'b0, 6'b000000, 1'b0, 3'd0);
      add(1'b0, 6'b000110, 1'b1, 6'b000010, 1'b1, 3'd1);
      add(1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0, 3'd0);
      add(1'b0, 6'b010000, 1'b1, 6'b010000, 1'b1, 3'd4);

      // Reset with flush and valid requests pending: nothing granted, outputs cleared.
      @(negedge clk);
      check("reset_ready", 192'(req_ready), 192'(6'b000000));
      @(posedge clk); #1;
      check("reset_wb_valid", 192'(wb_valid), 192'(1'b0));
      check("reset_wb_payload", 192'({wb_trans_id, wb_result, wb_ex, wb_src}), 192'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int n = 0; n < vecs.size(); n++) begin
         flush     = vecs[n].flush;
         req_valid = vecs[n].vld;
         wb_ready  = vecs[n].wrdy;
         #1;
         check($sformatf("ready[%0d]", n), 192'(req_ready), 192'(vecs[n].exp_rdy));
         @(posedge clk); #1;
         check($sformatf("wb_valid[%0d]", n), 192'(wb_valid), 192'(vecs[n].exp_wv));
         if (vecs[n].exp_wv) begin
            check($sformatf("wb_src[%0d]", n), 192'(wb_src), 192'(vecs[n].exp_src));
            check($sformatf("wb_trans_id[%0d]", n), 192'(wb_trans_id),
                  192'(req_trans_id[vecs[n].exp_src]));
            check($sformatf("wb_result[%0d]", n), 192'(wb_result),
                  192'(req_result[vecs[n].exp_src]));
            check($sformatf("wb_ex[%0d]", n), 192'(wb_ex), 192'(req_ex[vecs[n].exp_src]));
         end
         @(negedge clk);
      end

      // Reset in the middle of backpressure; pointer must restart at unit 0.
      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = 6'b111111;
      wb_ready  = 1'b0;
      #1;
      check("midreset_ready", 192'(req_ready), 192'(6'b000000));
      @(posedge clk); #1;
      check("midreset_wb_valid", 192'(wb_valid), 192'(1'b0));
      check("midreset_wb_payload", 192'({wb_trans_id, wb_result, wb_ex, wb_src}), 192'(0));
      @(negedge clk);
      rst      = 1'b0;
      wb_ready = 1'b1;
      #1;
      check("post_reset_ready", 192'(req_ready), 192'(6'b000001));
      @(posedge clk); #1;
      check("post_reset_src", 192'(wb_src), 192'(3'd0));
      check("post_reset_trans_id", 192'(wb_trans_id), 192'(3'd2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
